// File: rtl/seq_detect_sched.sv
// Two symbol streams share one 1-2-3 sequence detector through a burst-limited
// round-robin grant; detector state and counters are kept per stream.

module seq_detect_lane #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc,
    input  logic             clr,
    input  logic [1:0]       nxt,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= 2'd0;
            cnt   <= '0;
        end else begin
            if (acc) cnt <= cnt + 1'b1;
            // clear beats a simultaneous accept; the count still advances
            if (clr)      state <= 2'd0;
            else if (acc) state <= nxt;
        end
    end
endmodule

module seq_detect_sched #(
    parameter int BURST = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       num0,
    input  logic             valid0,
    output logic             ready0,
    input  logic             clr0,
    input  logic [1:0]       num1,
    input  logic             valid1,
    output logic             ready1,
    input  logic             clr1,
    output logic             ans0,
    output logic             ans1,
    output logic             hit,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
);
    localparam int NUM_LANES = 2;
    localparam logic [3:0] BURST_W = 4'(BURST);

    typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, DONE = 2'd3} st_t;

    logic [NUM_LANES-1:0]            valid, clr, ready;
    logic [NUM_LANES-1:0][1:0]       num, st;
    logic [NUM_LANES-1:0][CNT_W-1:0] cnt;

    assign valid = {valid1, valid0};
    assign clr   = {clr1, clr0};
    assign num   = {num1, num0};

    // scheduler
    logic       owner, owner_nxt;
    logic [3:0] bc, bc_nxt;

    always_comb begin
        ready     = '0;
        owner_nxt = owner;
        bc_nxt    = bc;
        if (valid[owner] && (bc < BURST_W || !valid[~owner])) begin
            ready[owner] = 1'b1;
            bc_nxt       = (bc == BURST_W) ? BURST_W : 4'(bc + 4'd1);
        end else if (valid[~owner]) begin
            ready[~owner] = 1'b1;
            owner_nxt     = ~owner;
            bc_nxt        = 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner <= 1'b0;
            bc    <= 4'd0;
        end else begin
            owner <= owner_nxt;
            bc    <= bc_nxt;
        end
    end

    // shared detector next-state, muxed onto whichever stream holds the grant
    logic       sel, any;
    st_t        cur, nxt;
    logic [1:0] sym;
    logic       det;

    assign sel = ready[1];
    assign any = |ready;
    assign cur = st_t'(st[sel]);
    assign sym = num[sel];

    always_comb begin
        nxt = S0;
        case (cur)
            S0:      nxt = (sym == 2'd1) ? S1 : S0;
            S1:      nxt = (sym == 2'd2) ? S2 : (sym == 2'd1) ? S1 : S0;
            S2:      nxt = (sym == 2'd3) ? DONE : (sym == 2'd1) ? S1 : S0;
            default: nxt = DONE;
        endcase
    end

    assign det = any && !clr[sel] && cur == S2 && sym == 2'd3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hit <= 1'b0;
        else        hit <= det;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        seq_detect_lane #(.CNT_W(CNT_W)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .acc   (ready[i]),
            .clr   (clr[i]),
            .nxt   (nxt),
            .state (st[i]),
            .cnt   (cnt[i])
        );
    end

    assign ready0 = ready[0];
    assign ready1 = ready[1];
    assign ans0   = st[0] == DONE;
    assign ans1   = st[1] == DONE;
    assign cnt0   = cnt[0];
    assign cnt1   = cnt[1];
endmodule

// File: tb/tb_seq_detect_sched.sv
// Randomized + directed bench for seq_detect_sched with a queue-based scoreboard
// fed by a pattern-matching reference model.

module tb_seq_detect_sched;
    localparam int BURST = 4;
    localparam int CNT_W = 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] num0 = '0, num1 = '0;
    logic valid0 = 0, valid1 = 0, clr0 = 0, clr1 = 0;
    logic ready0, ready1, ans0, ans1, hit;
    logic [CNT_W-1:0] cnt0, cnt1;

    always #5 clk = ~clk;

    seq_detect_sched #(.BURST(BURST), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .num0(num0), .valid0(valid0), .ready0(ready0), .clr0(clr0),
        .num1(num1), .valid1(valid1), .ready1(ready1), .clr1(clr1),
        .ans0(ans0), .ans1(ans1), .hit(hit), .cnt0(cnt0), .cnt1(cnt1)
    );

    typedef struct packed { logic r0, r1; } rdy_t;
    typedef struct packed {
        logic a0, a1, h;
        logic [CNT_W-1:0] c0, c1;
    } st_exp_t;

    rdy_t    exp_rdy[$];
    st_exp_t exp_st[$];

    int checks = 0, errors = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: stream history since last clear plus round-robin run length
    int               m_owner, m_run;
    int               hist[2][$];
    bit               done[2];
    logic [CNT_W-1:0] m_cnt[2];

    task automatic model_reset();
        m_owner = 0; m_run = 0;
        for (int s = 0; s < 2; s++) begin
            hist[s].delete(); done[s] = 0; m_cnt[s] = '0;
        end
    endtask

    task automatic step(bit v0, logic [1:0] n0, bit c0, bit v1, logic [1:0] n1, bit c1);
        bit v[2], c[2];
        int sym[2];
        int g, oth;
        bit h;
        @(negedge clk);
        valid0 = v0; num0 = n0; clr0 = c0;
        valid1 = v1; num1 = n1; clr1 = c1;
        v[0] = v0; v[1] = v1; c[0] = c0; c[1] = c1; sym[0] = n0; sym[1] = n1;
        #1;
        g = -1; oth = 1 - m_owner;
        if (v[m_owner] && (m_run < BURST || !v[oth])) begin
            g = m_owner; m_run = (m_run < BURST) ? m_run + 1 : BURST;
        end else if (v[oth]) begin
            g = oth; m_owner = oth; m_run = 1;
        end
        exp_rdy.push_back('{r0: (g == 0), r1: (g == 1)});
        h = 0;
        for (int s = 0; s < 2; s++) begin
            if (g == s) m_cnt[s] = m_cnt[s] + 1'b1;
            if (c[s]) begin
                hist[s].delete(); done[s] = 0;
            end else if (g == s) begin
                if (!done[s] && hist[s].size() >= 2 && hist[s][$-1] == 1 &&
                    hist[s][$] == 2 && sym[s] == 3) begin
                    done[s] = 1; h = 1;
                end
                hist[s].push_back(sym[s]);
                if (hist[s].size() > 2) void'(hist[s].pop_front());
            end
        end
        exp_st.push_back('{a0: done[0], a1: done[1], h: h, c0: m_cnt[0], c1: m_cnt[1]});
    endtask

    task automatic check_zero();
        chk("rst_ans0", ans0, 0);
        chk("rst_ans1", ans1, 0);
        chk("rst_hit", hit, 0);
        chk("rst_cnt0", cnt0, 0);
        chk("rst_cnt1", cnt1, 0);
        chk("rst_rdy0", ready0, 0);
        chk("rst_rdy1", ready1, 0);
    endtask

    // asynchronous reset pulse placed between clock edges
    task automatic do_reset();
        @(posedge clk);
        #3;
        valid0 = 0; valid1 = 0; clr0 = 0; clr1 = 0;
        rst_n = 1'b0;
        #1;
        check_zero();
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    // monitor: ready checked mid-low-phase, registered outputs just after the edge
    initial begin
        rdy_t    r;
        st_exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_rdy.size() > 0) begin
                r = exp_rdy.pop_front();
                chk("ready0", ready0, r.r0);
                chk("ready1", ready1, r.r1);
                chk("one_hot", int'(ready0 & ready1), 0);
            end
            @(posedge clk);
            #1;
            if (exp_st.size() > 0) begin
                e = exp_st.pop_front();
                chk("ans0", ans0, e.a0);
                chk("ans1", ans1, e.a1);
                chk("hit", hit, e.h);
                chk("cnt0", cnt0, e.c0);
                chk("cnt1", cnt1, e.c1);
            end
        end
    end

    initial begin
        int seq0[10] = '{1, 1, 2, 2, 0, 1, 2, 3, 1, 1};
        int s0[3] = '{1, 2, 3};
        int s1[3] = '{2, 3, 1};
        model_reset();
        #2;
        check_zero();
        @(posedge clk);
        #3 rst_n = 1'b1;

        // stream 0 alone
        foreach (seq0[i]) step(1, 2'(seq0[i]), 0, 0, 2'd0, 0);
        step(0, 2'd0, 0, 0, 2'd0, 0);

        // both streams saturated
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 2'd0, 0, 1, 2'd0, 0);

        // alternating valid interleave
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1, 2'(s0[i]), 0, 0, 2'd0, 0);
            step(0, 2'd0, 0, 1, 2'(s1[i]), 0);
        end

        // clear racing the closing 3, then a clean 1,2,3
        do_reset();
        step(1, 2'd1, 0, 0, 2'd0, 0);
        step(1, 2'd2, 0, 0, 2'd0, 0);
        step(1, 2'd3, 1, 0, 2'd0, 0);
        for (int i = 0; i < 3; i++) step(1, 2'(s0[i]), 0, 0, 2'd0, 0);

        // DONE persistence on stream 1, then clear
        do_reset();
        for (int i = 0; i < 3; i++) step(0, 2'd0, 0, 1, 2'(s0[i]), 0);
        step(0, 2'd0, 0, 1, 2'd0, 0);
        step(0, 2'd0, 0, 1, 2'd0, 0);
        step(0, 2'd0, 0, 1, 2'd3, 0);
        step(0, 2'd0, 0, 0, 2'd0, 1);
        step(0, 2'd0, 0, 0, 2'd0, 0);

        // reset mid-burst with stream 0 holding a partial match
        do_reset();
        step(1, 2'd1, 0, 1, 2'd0, 0);
        step(1, 2'd2, 0, 1, 2'd0, 0);
        do_reset();
        step(1, 2'd3, 0, 1, 2'd0, 0);
        step(0, 2'd0, 0, 0, 2'd0, 0);

        // random traffic
        do_reset();
        for (int i = 0; i < 1500; i++)
            step(bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 15) == 0),
                 bit'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                 bit'($urandom_range(0, 15) == 0));
        step(0, 2'd0, 0, 0, 2'd0, 0);
        repeat (3) @(posedge clk);
        chk("sb_drained", exp_rdy.size() + exp_st.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
